// File: rtl/sr_bist_pkg.sv
// Shared types and constants for the serial delay-line BIST driver.
// The PRBS7 feedback helper is shared by the generator and the checker.
package sr_bist_pkg;

  typedef enum logic [2:0] {IDLE, FLUSH, PROBE, RUN, DONE} state_e;

  localparam int             PRBS_W     = 7;
  localparam logic [PRBS_W-1:0] PRBS7_SEED = 7'h7F;
  localparam int             TAP_HI     = 6;
  localparam int             TAP_LO     = 5;

  // x^7 + x^6 + 1: next bit from the two oldest history positions
  function automatic logic prbs7_fb(input logic [PRBS_W-1:0] s);
    return s[TAP_HI] ^ s[TAP_LO];
  endfunction

endpackage

// File: rtl/sr_bist_prbs7.sv
// 7-bit Fibonacci LFSR (x^7+x^6+1) with synchronous seed load and advance enable.
module sr_bist_prbs7
  import sr_bist_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  output logic prbs_bit
);

  logic [PRBS_W-1:0] lfsr_q;

  assign prbs_bit = prbs7_fb(lfsr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= PRBS7_SEED;
    end else if (load) begin
      lfsr_q <= PRBS7_SEED;
    end else if (en) begin
      lfsr_q <= {lfsr_q[PRBS_W-2:0], prbs_bit};
    end
  end

endmodule

// File: rtl/sr_bist_driver.sv
// BIST transmit/check end for the serial latch delay line: flush, latency probe,
// then PRBS7 stream with a self-synchronising error checker.
module sr_bist_driver
  import sr_bist_pkg::*;
#(
  parameter int BIT_PERIOD = 2,
  parameter int MAX_LAT    = 512,
  parameter int LAT_W      = 10,
  parameter int NUM_BITS   = 1024,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             sr_tx,
  input  logic             sr_rx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fault,
  output logic [LAT_W-1:0] latency,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CW = $clog2(NUM_BITS * BIT_PERIOD + MAX_LAT + 1);
  localparam int TW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [PRBS_W-1:0] hist_q, hist_d;
  logic              tx_d, busy_d, done_d, pass_d, fault_d;
  logic [LAT_W-1:0]  lat_d;
  logic [ERR_W-1:0]  err_d;
  logic              tick, prbs_load, prbs_bit, exp_bit, chk_en;
  logic [CW-1:0]     run_end, warm_end;

  sr_bist_prbs7 u_prbs (
    .clk      (clk),
    .rst      (rst),
    .en       (tick),
    .load     (prbs_load),
    .prbs_bit (prbs_bit)
  );

  // RUN lasts NUM_BITS ticks plus the measured latency so the tail can drain.
  assign run_end  = CW'(NUM_BITS * BIT_PERIOD - 1) + CW'(latency);
  // Strictly after this RUN cycle the history holds seven genuine PRBS bits.
  assign warm_end = CW'(latency) + CW'(7 * BIT_PERIOD);
  assign exp_bit  = prbs7_fb(hist_q);
  assign chk_en   = (cyc_q > warm_end);

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    tcnt_d    = tcnt_q;
    hist_d    = hist_q;
    tx_d      = 1'b0;
    done_d    = done;
    pass_d    = pass;
    fault_d   = fault;
    lat_d     = latency;
    err_d     = err_cnt;
    tick      = 1'b0;
    prbs_load = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = FLUSH;
          cyc_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fault_d = 1'b0;
          lat_d   = '0;
          err_d   = '0;
        end
      end
      FLUSH: begin
        if (cyc_q == CW'(MAX_LAT - 1)) begin
          cyc_d = '0;
          if (sr_rx) begin
            fault_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d = PROBE;
            tx_d    = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      PROBE: begin
        tx_d = (cyc_q + CW'(1)) < CW'(BIT_PERIOD);
        if (sr_rx) begin
          lat_d     = LAT_W'(cyc_q);
          state_d   = RUN;
          cyc_d     = '0;
          tcnt_d    = '0;
          prbs_load = 1'b1;
          tx_d      = 1'b0;
        end else if (cyc_q == CW'(MAX_LAT)) begin
          fault_d = 1'b1;
          lat_d   = '0;
          state_d = DONE;
          tx_d    = 1'b0;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      RUN: begin
        cyc_d  = cyc_q + CW'(1);
        tick   = (tcnt_q == '0);
        tcnt_d = (tcnt_q == TW'(BIT_PERIOD - 1)) ? '0 : tcnt_q + TW'(1);
        tx_d   = sr_tx;
        if (tick) begin
          tx_d   = prbs_bit;
          hist_d = {hist_q[PRBS_W-2:0], sr_rx};
          if (chk_en && (sr_rx != exp_bit) && (err_cnt != {ERR_W{1'b1}})) begin
            err_d = err_cnt + ERR_W'(1);
          end
        end
        if (cyc_q == run_end) begin
          state_d = DONE;
          tx_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == DONE) && (state_q != DONE)) begin
      done_d = 1'b1;
      pass_d = !fault_d && (err_d == '0);
    end
    busy_d = (state_d == FLUSH) || (state_d == PROBE) || (state_d == RUN);
  end

  // Single register stage: every output is a flop, no rx-to-tx combinational path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      tcnt_q  <= '0;
      hist_q  <= '0;
      sr_tx   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      fault   <= 1'b0;
      latency <= '0;
      err_cnt <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      tcnt_q  <= tcnt_d;
      hist_q  <= hist_d;
      sr_tx   <= tx_d;
      busy    <= busy_d;
      done    <= done_d;
      pass    <= pass_d;
      fault   <= fault_d;
      latency <= lat_d;
      err_cnt <= err_d;
    end
  end

endmodule

// File: tb/tb_sr_bist_driver.sv
// Directed bench: three driver instances, each looped through an ideal D-cycle delay line.
module tb_sr_bist_driver;

  localparam int D = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

  logic       tx_a, rx_a, busy_a, done_a, pass_a, fault_a;
  logic [9:0] lat_a;
  logic [15:0] err_a;
  logic       tx_b, rx_b, busy_b, done_b, pass_b, fault_b;
  logic [9:0] lat_b;
  logic [3:0] err_b;
  logic       tx_c, rx_c, busy_c, done_c, pass_c, fault_c;
  logic [5:0] lat_c;
  logic [15:0] err_c;

  // line modes: 0 ideal, 1 stuck-0, 2 stuck-1, 3 inverted
  int   mode_a = 0, mode_b = 0;
  logic flip_a = 1'b0;
  logic [15:0] dl_a = '0, dl_b = '0, dl_c = '0;
  int   tx_ones_a = 0;
  int   tests = 0, fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dl_a      <= {dl_a[14:0], tx_a};
    dl_b      <= {dl_b[14:0], tx_b};
    dl_c      <= {dl_c[14:0], tx_c};
    tx_ones_a <= tx_ones_a + (tx_a ? 1 : 0);
  end

  function automatic logic line_out(input int mode, input logic b);
    case (mode)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return ~b;
      default: return b;
    endcase
  endfunction

  assign rx_a = line_out(mode_a, dl_a[D-1]) ^ flip_a;
  assign rx_b = line_out(mode_b, dl_b[D-1]);
  assign rx_c = dl_c[D-1];

  sr_bist_driver dut_a (
    .clk(clk), .rst(rst), .start(start_a), .sr_tx(tx_a), .sr_rx(rx_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fault(fault_a),
    .latency(lat_a), .err_cnt(err_a)
  );

  sr_bist_driver #(.ERR_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .sr_tx(tx_b), .sr_rx(rx_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fault(fault_b),
    .latency(lat_b), .err_cnt(err_b)
  );

  sr_bist_driver #(.BIT_PERIOD(1), .MAX_LAT(32), .LAT_W(6), .NUM_BITS(64)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .sr_tx(tx_c), .sr_rx(rx_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .fault(fault_c),
    .latency(lat_c), .err_cnt(err_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic pulse_start(input int sel);
    @(negedge clk);
    case (sel)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // n = posedges after the start-sampling edge until done is seen
  task automatic wait_done(input int sel, input int limit, output int n, output logic busy_prev);
    logic d, b, prev;
    n = 0;
    d = 1'b0;
    prev = 1'b0;
    while (!d && n < limit) begin
      @(posedge clk);
      #1;
      n++;
      d = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
      b = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
      if (!d) prev = b;
    end
    busy_prev = prev;
    chk($sformatf("done_seen%0d", sel), 32'(d), 32'd1);
  endtask

  initial begin
    int   n;
    int   ones0;
    logic bp;

    repeat (2) @(negedge clk);
    chk("rst_tx",    32'(tx_a),    32'd0);
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_done",  32'(done_a),  32'd0);
    chk("rst_pass",  32'(pass_a),  32'd0);
    chk("rst_fault", 32'(fault_a), 32'd0);
    chk("rst_lat",   32'(lat_a),   32'd0);
    chk("rst_err",   32'(err_a),   32'd0);
    rst = 1'b0;

    // clean run through the ideal line
    pulse_start(0);
    wait_done(0, 4000, n, bp);
    chk("t1_lat",      32'(lat_a),   32'd10);
    chk("t1_err",      32'(err_a),   32'd0);
    chk("t1_fault",    32'(fault_a), 32'd0);
    chk("t1_pass",     32'(pass_a),  32'd1);
    chk("t1_busy",     32'(busy_a),  32'd0);
    chk("t1_busy_pre", 32'(bp),      32'd1);

    // one flipped bit lands on exactly one tick
    pulse_start(0);
    repeat (1200) @(negedge clk);
    flip_a = 1'b1;
    repeat (2) @(negedge clk);
    flip_a = 1'b0;
    wait_done(0, 4000, n, bp);
    chk("t2_err",  32'(err_a),  32'd3);
    chk("t2_pass", 32'(pass_a), 32'd0);
    chk("t2_lat",  32'(lat_a),  32'd10);

    // line stuck at 0: probe times out
    mode_a = 1;
    pulse_start(0);
    wait_done(0, 2000, n, bp);
    chk("t3_cycles", 32'(n),       32'd1025);
    chk("t3_fault",  32'(fault_a), 32'd1);
    chk("t3_lat",    32'(lat_a),   32'd0);
    chk("t3_pass",   32'(pass_a),  32'd0);

    // line stuck at 1: fault at end of flush, tx never raised
    mode_a = 2;
    ones0 = tx_ones_a;
    pulse_start(0);
    wait_done(0, 2000, n, bp);
    chk("t4_cycles", 32'(n),               32'd512);
    chk("t4_fault",  32'(fault_a),         32'd1);
    chk("t4_tx_hi",  32'(tx_ones_a - ones0), 32'd0);
    chk("t4_pass",   32'(pass_a),          32'd0);

    // async reset mid-RUN after errors have accumulated
    mode_a = 0;
    pulse_start(0);
    repeat (1200) @(negedge clk);
    flip_a = 1'b1;
    repeat (2) @(negedge clk);
    flip_a = 1'b0;
    repeat (40) @(negedge clk);
    chk("t5_err_pre",  32'(err_a),  32'd3);
    chk("t5_busy_pre", 32'(busy_a), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_tx",   32'(tx_a),   32'd0);
    chk("t5_busy", 32'(busy_a), 32'd0);
    chk("t5_err",  32'(err_a),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulse_start(0);
    wait_done(0, 4000, n, bp);
    chk("t5_pass", 32'(pass_a), 32'd1);
    chk("t5_err2", 32'(err_a),  32'd0);

    // 4-bit error counter saturates on an inverted line; restart while busy ignored
    pulse_start(1);
    repeat (1200) @(negedge clk);
    mode_b = 3;
    repeat (200) @(negedge clk);
    chk("t6_sat", 32'(err_b), 32'hF);
    pulse_start(1);
    chk("t6_ign_busy", 32'(busy_b), 32'd1);
    chk("t6_ign_done", 32'(done_b), 32'd0);
    chk("t6_ign_err",  32'(err_b),  32'hF);
    wait_done(1, 4000, n, bp);
    chk("t6_err",   32'(err_b),   32'hF);
    chk("t6_pass",  32'(pass_b),  32'd0);
    chk("t6_fault", 32'(fault_b), 32'd0);
    mode_b = 0;

    // one-cycle bit period
    pulse_start(2);
    wait_done(2, 400, n, bp);
    chk("bp1_lat",  32'(lat_c),  32'd10);
    chk("bp1_err",  32'(err_c),  32'd0);
    chk("bp1_pass", 32'(pass_c), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
